imm_extend_pipe: RTL

Parametrised, registered immediate generator for the decode stage. Takes instruction bits [31:7] and an immediate-format select, and produces the extended immediate at DATA_WIDTH (32 or 64) alongside a caller tag. Adds two formats beyond the base set: CSR zimm and shift amount. Output passes through a 2-entry skid buffer with valid/ready handshaking, stall and flush, so decode can sit between fetch and execute pipeline registers without combinational ready paths.

---
 rtl/imm_extend_pipe.sv | 135 +++++++++++++
 1 files changed

// File: rtl/imm_extend_pipe.sv
// Decode-stage immediate generator: combinational format decode feeding a
// 2-entry registered skid FIFO with valid/ready, stall and flush.

module imm_decode #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [24:0]           instr,
    input  logic [2:0]            imm_src,
    output logic [DATA_WIDTH-1:0] imm,
    output logic                  illegal
);
    // instr holds instruction bits [31:7], so instruction bit k is instr[k-7].
    // Every format is first built as a 32-bit sign-correct value; the zero-extended
    // formats always have bit 31 clear, so a plain sign extension widens all of them.
    logic [31:0] v32;

    always_comb begin
        v32     = '0;
        illegal = 1'b0;
        case (imm_src)
            3'b000: v32 = {{20{instr[24]}}, instr[24:13]};
            3'b001: v32 = {{20{instr[24]}}, instr[24:18], instr[4:0]};
            3'b010: v32 = {{20{instr[24]}}, instr[0], instr[23:18], instr[4:1], 1'b0};
            3'b011: v32 = {{12{instr[24]}}, instr[12:5], instr[13], instr[23:14], 1'b0};
            3'b100: v32 = {instr[24:5], 12'b0};
            3'b101: v32 = {27'b0, instr[12:8]};
            3'b110: v32 = (DATA_WIDTH == 64) ? {26'b0, instr[18:13]} : {27'b0, instr[17:13]};
            default: illegal = 1'b1;
        endcase
    end

    generate
        if (DATA_WIDTH == 64) begin : g_w64
            assign imm = {{32{v32[31]}}, v32};
        end else if (DATA_WIDTH == 32) begin : g_w32
            assign imm = v32;
        end else begin : g_bad
            $error("imm_decode: DATA_WIDTH must be 32 or 64");
        end
    endgenerate
endmodule

module imm_extend_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [24:0]           instr,
    input  logic [2:0]            imm_src,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] imm_ext,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  illegal
);
    typedef struct packed {
        logic [DATA_WIDTH-1:0] imm;
        logic [TAG_WIDTH-1:0]  tag;
        logic                  ill;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t state, state_nxt;
    logic   head, tail, head_nxt, tail_nxt;
    entry_t mem [2];
    entry_t dec_e, head_e;
    logic   acc, pop;

    imm_decode #(.DATA_WIDTH(DATA_WIDTH)) u_dec (
        .instr   (instr),
        .imm_src (imm_src),
        .imm     (dec_e.imm),
        .illegal (dec_e.ill)
    );
    assign dec_e.tag = in_tag;

    // Ready looks only at registered state (and reset), never at out_ready.
    assign in_ready  = rst_n && (state != FULL);
    assign out_valid = (state != EMPTY);
    assign acc       = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_nxt = state;
        head_nxt  = head;
        tail_nxt  = tail;
        if (flush) begin
            state_nxt = EMPTY;
            head_nxt  = 1'b0;
            tail_nxt  = 1'b0;
        end else begin
            if (acc) tail_nxt = ~tail;
            if (pop) head_nxt = ~head;
            case (state)
                EMPTY:   if (acc) state_nxt = ONE;
                ONE:     if (acc && !pop) state_nxt = FULL;
                         else if (pop && !acc) state_nxt = EMPTY;
                FULL:    if (pop) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else begin
            state <= state_nxt;
            head  <= head_nxt;
            tail  <= tail_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (acc && !flush) begin
            mem[tail] <= dec_e;
        end
    end

    assign head_e  = mem[head];
    assign imm_ext = out_valid ? head_e.imm : '0;
    assign out_tag = out_valid ? head_e.tag : '0;
    assign illegal = out_valid ? head_e.ill : 1'b0;
endmodule
